instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Takes decoded RISC-V instruction fields over a valid/ready handshake,
//   checks them, packs them into a 32-bit instruction word and writes it to
//   a word-addressed instruction memory at successive byte addresses.
//
// State table
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   ACCEPT | in_ready=1, waiting for in_valid to capture the fields
//   ENCODE | captured fields checked; word packed or error raised
//   WRITE  | mem_we=1 for one cycle, address/count advance at its end
//   DONE   | program finished or memory full; sticky until start
//   ERROR  | invalid instruction seen; sticky until start
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 clears address/count/flags and arms the encoder
//   in_valid / in_ready   field handshake
//   tipo, opcode, rd, rs1, rs2, funct3, funct7, immediate, negativo, last
//                         instruction fields
//   mem_we, mem_addr, mem_wdata   memory write port (byte address)
//   count                 words written since start
//   done, full, error     status flags
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        tipo,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [11:0]       immediate,
    input  logic              negativo,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-2:0] count,
    output logic              done,
    output logic              full,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_ENCODE, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t state;

    logic [2:0]  tipo_q;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [11:0] imm_q;
    logic        neg_q;
    logic        last_q;

    logic [11:0]       imm12;
    logic [12:1]       off_hi;
    logic [31:0]       enc_word;
    logic              fmt_ok;
    logic              enc_ok;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        imm12 = imm_q;
        if (tipo_q == 3'b001 && neg_q)
            imm12 = ~imm_q + 12'd1;

        // Branch offsets are always even (odd ones are rejected), so only
        // bits [12:1] of the signed 13-bit offset are needed; negating the
        // halved magnitude gives exactly those bits.
        off_hi = {1'b0, imm_q[11:1]};
        if (neg_q)
            off_hi = 12'd0 - {1'b0, imm_q[11:1]};

        fmt_ok = 1'b1;
        case (tipo_q)
            3'b000, 3'b001:
                enc_word = {imm12, rs1_q, funct3_q, rd_q, opcode_q};
            3'b010:
                enc_word = {imm12[11:5], rs2_q, rs1_q, funct3_q, imm12[4:0], opcode_q};
            3'b011:
                enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            3'b110:
                enc_word = {off_hi[12], off_hi[10:5], rs2_q, rs1_q, funct3_q,
                            off_hi[4:1], off_hi[11], opcode_q};
            default: begin
                enc_word = 32'd0;
                fmt_ok   = 1'b0;
            end
        endcase

        enc_ok = fmt_ok && (opcode_q[6:4] == tipo_q) &&
                 !(tipo_q == 3'b110 && imm_q[0]);

        next_addr = mem_addr + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            error     <= 1'b0;
            tipo_q    <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            imm_q     <= '0;
            neg_q     <= 1'b0;
            last_q    <= 1'b0;
        end else if (start) begin
            // start overrides any handshake or write in progress
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            count    <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (in_valid) begin
                        tipo_q   <= tipo;
                        opcode_q <= opcode;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        funct3_q <= funct3;
                        funct7_q <= funct7;
                        imm_q    <= immediate;
                        neg_q    <= negativo;
                        last_q   <= last;
                        in_ready <= 1'b0;
                        state    <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    if (enc_ok) begin
                        mem_wdata <= enc_word;
                        mem_we    <= 1'b1;
                        state     <= S_WRITE;
                    end else begin
                        error <= 1'b1;
                        state <= S_ERROR;
                    end
                end
                S_WRITE: begin
                    mem_we   <= 1'b0;
                    mem_addr <= next_addr;
                    count    <= count + (ADDR_W-1)'(1);
                    if (next_addr == '0) begin
                        full  <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (last_q) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_ACCEPT;
                    end
                end
                default: ;  // IDLE, DONE, ERROR hold until start
            endcase
        end
    end

endmodule
